hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage mini CPU. It tracks destination registers in flight in the EXE and MEM stages. From that it drives the operand-forwarding selects for the ID-stage operand muxes and detects load-use hazards, which it resolves by stalling PC/IFID and injecting a bubble into IDEXE. It also drains and halts the pipeline once the fetch address reaches a program-end limit.

## Interface
Parameters:
- `PC_LIMIT`, 32'd128: fetch address at or above which the core drains and halts.
- `DRAIN_CYCLES`, 4: non-stalled cycles spent in DRAIN before HALT.
- `CNT_W`, 16: width of the stall counter.

Ports:
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `pc` input, 32 bits: current fetch address.
- `id_rs` input, 5 bits: rs field of the ID-stage instruction.
- `id_rt` input, 5 bits: rt field of the ID-stage instruction.
- `id_uses_rt` input, 1 bit: ID instruction reads rt as a source (R-type, store).
- `id_wreg` input, 1 bit: ID instruction writes the register file.
- `id_m2reg` input, 1 bit: ID instruction is a load.
- `id_dest` input, 5 bits: ID destination (rd or rt, already muxed by regrt).
- `pc_en` output, 1 bit: PC register load enable.
- `ifid_en` output, 1 bit: IFID load enable.
- `ifid_flush` output, 1 bit: IFID loads a NOP (all zero) instead of the fetched word.
- `idexe_bubble` output, 1 bit: IDEXE loads zero control bits (wreg=m2reg=wmem=0).
- `fwda` output, 2 bits: select for operand A. 00 = regfile qa, 01 = EXE ALU result, 10 = MEM ALU result, 11 = MEM data-memory output.
- `fwdb` output, 2 bits: same encoding as `fwda`, for operand B.
- `halted` output, 1 bit: core is in HALT.
- `stall_count` output, CNT_W bits: saturating count of load-use stall cycles.

## Operation
- Scoreboard holds two slots, E and M. Each slot is {wreg, m2reg, dest}.
- Each clock edge:
  - M <= E.
  - E <= ID info, or all zero when `idexe_bubble` is 1.
- A slot "matches" register r when slot.wreg=1, slot.dest=r and r≠0. Register 0 never matches.
- Forwarding for A, using r = `id_rs`:
  - E matches and E.m2reg=0: 01.
  - Else M matches: 10 if M.m2reg=0, 11 if M.m2reg=1.
  - Else: 00.
  - E takes priority over M.
- Forwarding for B uses the same rule with r = `id_rt`. It is forced to 00 when `id_uses_rt`=0.
- WB-to-ID is not forwarded. The register file must write-through on a same-cycle read.
- load_use = E.wreg & E.m2reg & E.dest≠0 & (E.dest=id_rs | (id_uses_rt & E.dest=id_rt)).
- FSM states:
  - RUN:
    - load_use=1: pc_en=0, ifid_en=0, idexe_bubble=1.
    - Otherwise all enables are 1 and the bubble is 0.
    - Goes to DRAIN when `pc` ≥ PC_LIMIT on a cycle without load_use; the counter is loaded with DRAIN_CYCLES.
  - DRAIN:
    - pc_en=0.
    - ifid_flush=1, so ID holds a NOP after the first DRAIN cycle.
    - load_use still stalls: ifid_en=0, flush suppressed, bubble=1, counter held.
    - The counter decrements on non-stalled cycles. When it reaches 0, go to HALT.
  - HALT: pc_en=0, ifid_en=0, idexe_bubble=1, halted=1. Stays in HALT until `rst`.
- stall_count increments on every load_use cycle and saturates at 2^CNT_W−1.

## Timing
- fwda, fwdb, load_use, pc_en, ifid_en, ifid_flush and idexe_bubble are combinational from the inputs and registered state, valid in the same cycle. They have no extra latency.
- A load-use stall lasts exactly one cycle. On the next cycle the load is in M and is forwarded with 11.
- Reset takes effect on the first rising edge with rst=1. After reset:
  - State = RUN.
  - E and M slots are zero.
  - stall_count = 0.
  - halted = 0.
  - Outputs: pc_en=1, ifid_en=1, ifid_flush=0, idexe_bubble=0, fwda=fwdb=00.
- Reset during DRAIN or HALT returns to RUN immediately; the slots are cleared.
- If the halt condition and load_use occur together in RUN, the stall takes precedence. DRAIN is entered on the next cycle in which `pc` ≥ PC_LIMIT and load_use=0.
- The `pc` value is ignored while in DRAIN or HALT.

## Structure
- Shared package `hazard_pkg` holds:
  - Forwarding select constants: FWD_RF, FWD_EALU, FWD_MALU, FWD_MMEM.
  - FSM state encoding: RUN, DRAIN, HALT.
  - Scoreboard slot record layout.
- Sub-module `hazard_scoreboard` implements the two-slot E/M shift register with bubble insert. The FSM, comparators and stall counter live in `hazard_ctrl`.

## Test plan
- Back-to-back ALU writes. `add r3` is followed next cycle by an ID instruction reading rs=3, then one more later. Required: fwda=01 in the first case and 10 in the second; no stall.
- Load-use. `lw r5` is in E and the ID instruction has rt=5 with id_uses_rt=1. Required: one cycle of pc_en=0, ifid_en=0, idexe_bubble=1; next cycle fwdb=11; stall_count=1.
- Register 0 and immediate operand.
  - E is writing r0 while ID reads r0: fwda=00, no stall.
  - A load to r7 with ID rt=7 and id_uses_rt=0: no stall, fwdb=00.
- Drain and halt. `pc` steps to 128 in RUN. Required: DRAIN with pc_en=0 and ifid_flush=1; halted=1 exactly 4 non-stalled cycles later; all enables low thereafter.
- Drain with load-use. load_use occurs on the first DRAIN cycle. Required: the counter is held, HALT is reached 5 cycles after DRAIN entry, stall_count increments by 1.
- Reset mid-HALT and saturation.
  - rst=1 for one cycle while in HALT. Required: RUN, halted=0, pc_en=1, slots clear.
  - With CNT_W=2, 5 load-use stalls leave stall_count=3.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   - Forwarding select encodings for the ID-stage operand muxes.
//   - FSM state encoding (RUN / DRAIN / HALT).
//   - Scoreboard slot layout and the forwarding-select helper.
package hazard_pkg;

  // Operand mux selects
  localparam logic [1:0] FWD_RF   = 2'b00;  // register file qa/qb
  localparam logic [1:0] FWD_EALU = 2'b01;  // EXE-stage ALU result
  localparam logic [1:0] FWD_MALU = 2'b10;  // MEM-stage ALU result
  localparam logic [1:0] FWD_MMEM = 2'b11;  // MEM-stage data-memory output

  // Controller FSM states
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  // One in-flight destination record
  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic [4:0] dest;
  } slot_t;

  // A slot produces register r only if it writes, targets r, and r is not r0.
  function automatic logic slot_match(input slot_t s, input logic [4:0] r);
    return s.wreg && (s.dest == r) && (r != 5'd0);
  endfunction

  // E beats M because it holds the younger write. A load in E has no data
  // yet, so it cannot forward; that case is the load-use stall instead.
  function automatic logic [1:0] fwd_sel(input slot_t e, input slot_t m,
                                         input logic [4:0] r);
    if (slot_match(e, r) && !e.m2reg) return FWD_EALU;
    if (slot_match(m, r))             return m.m2reg ? FWD_MMEM : FWD_MALU;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: two-slot E/M shift register of in-flight destinations.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   id_slot_i     - destination record of the instruction leaving ID
//   bubble_i      - load an empty record into E instead of id_slot_i
//   e_slot_o      - record of the instruction now in EXE
//   m_slot_o      - record of the instruction now in MEM
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  slot_t id_slot_i,
  input  logic  bubble_i,
  output slot_t e_slot_o,
  output slot_t m_slot_o
);

  slot_t e_q, m_q;

  // NOTE: reset is synchronous, so it lives inside the clocked block and
  // needs no sensitivity entry of its own; sequential state uses <= only.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= '0;
      m_q <= '0;
    end else begin
      m_q <= e_q;
      e_q <= bubble_i ? slot_t'('0) : id_slot_i;
    end
  end

  assign e_slot_o = e_q;
  assign m_slot_o = m_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use stall and drain/halt control
// for the 5-stage mini CPU.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   pc                           - current fetch address
//   id_rs, id_rt, id_uses_rt     - ID-stage source fields
//   id_wreg, id_m2reg, id_dest   - ID-stage destination info
//   pc_en, ifid_en, ifid_flush   - fetch-side pipeline controls
//   idexe_bubble                 - zero the control bits entering IDEXE
//   fwda, fwdb                   - operand A/B forwarding selects
//   halted                       - core is in HALT
//   stall_count                  - saturating count of load-use stall cycles
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter logic [31:0] PC_LIMIT     = 32'd128,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic [4:0]       id_dest,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idexe_bubble,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  slot_t id_slot, e_slot, m_slot;
  logic  load_use;

  logic [1:0]       state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  assign id_slot = '{wreg: id_wreg, m2reg: id_m2reg, dest: id_dest};

  hazard_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .id_slot_i (id_slot),
    .bubble_i  (idexe_bubble),
    .e_slot_o  (e_slot),
    .m_slot_o  (m_slot)
  );

  assign fwda = fwd_sel(e_slot, m_slot, id_rs);
  assign fwdb = id_uses_rt ? fwd_sel(e_slot, m_slot, id_rt) : FWD_RF;

  // A load in E whose result ID needs now cannot be forwarded until MEM.
  assign load_use = e_slot.wreg && e_slot.m2reg && (e_slot.dest != 5'd0) &&
                    ((e_slot.dest == id_rs) || (id_uses_rt && (e_slot.dest == id_rt)));

  always_comb begin
    // NOTE: every output and next-state signal gets a default first, so no
    // path through the case can leave one unassigned and infer a latch.
    state_d      = state_q;
    drain_d      = drain_q;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idexe_bubble = 1'b0;
    case (state_q)
      RUN: begin
        if (load_use) begin
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          idexe_bubble = 1'b1;
        end else if (pc >= PC_LIMIT) begin
          state_d = DRAIN;
          drain_d = DW'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        pc_en = 1'b0;
        if (load_use) begin
          // Hold IFID so the dependent instruction retries; counter frozen.
          ifid_en      = 1'b0;
          idexe_bubble = 1'b1;
        end else begin
          ifid_flush = 1'b1;
          if (drain_q > DW'(1)) begin
            drain_d = drain_q - DW'(1);
          end else begin
            drain_d = '0;
            state_d = HALT;
          end
        end
      end
      HALT: begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idexe_bubble = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (load_use && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      drain_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
    end
  end

  assign halted      = (state_q == HALT);
  assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Inputs change 1 time unit after the
// rising edge and outputs are sampled 1 time unit later, well away from the
// next edge. A second instance with CNT_W=2 shares the stimulus and is only
// examined for stall-counter saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_uses_rt, id_wreg, id_m2reg;

  logic        pc_en, ifid_en, ifid_flush, idexe_bubble, halted;
  logic [1:0]  fwda, fwdb;
  logic [15:0] stall_count;

  logic        pc_en2, ifid_en2, ifid_flush2, idexe_bubble2, halted2;
  logic [1:0]  fwda2, fwdb2;
  logic [1:0]  stall_count2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .pc(pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_dest(id_dest),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idexe_bubble(idexe_bubble), .fwda(fwda), .fwdb(fwdb),
    .halted(halted), .stall_count(stall_count)
  );

  hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .pc(pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_dest(id_dest),
    .pc_en(pc_en2), .ifid_en(ifid_en2), .ifid_flush(ifid_flush2),
    .idexe_bubble(idexe_bubble2), .fwda(fwda2), .fwdb(fwdb2),
    .halted(halted2), .stall_count(stall_count2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses_rt, input logic wreg,
                        input logic m2reg, input logic [4:0] dest);
    id_rs      = rs;
    id_rt      = rt;
    id_uses_rt = uses_rt;
    id_wreg    = wreg;
    id_m2reg   = m2reg;
    id_dest    = dest;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pc  = 32'd0;
    set_id(0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc_en !== 1'b1)        begin failures++; $display("FAIL reset_pc_en got=%0d exp=1", pc_en); end
    checks++; if (ifid_en !== 1'b1)      begin failures++; $display("FAIL reset_ifid_en got=%0d exp=1", ifid_en); end
    checks++; if (ifid_flush !== 1'b0)   begin failures++; $display("FAIL reset_flush got=%0d exp=0", ifid_flush); end
    checks++; if (idexe_bubble !== 1'b0) begin failures++; $display("FAIL reset_bubble got=%0d exp=0", idexe_bubble); end
    checks++; if (fwda !== 2'b00)        begin failures++; $display("FAIL reset_fwda got=%0d exp=0", fwda); end
    checks++; if (fwdb !== 2'b00)        begin failures++; $display("FAIL reset_fwdb got=%0d exp=0", fwdb); end
    checks++; if (halted !== 1'b0)       begin failures++; $display("FAIL reset_halted got=%0d exp=0", halted); end
    checks++; if (stall_count !== 16'd0) begin failures++; $display("FAIL reset_stall_count got=%0d exp=0", stall_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(1, 2, 1, 1, 0, 3);  // add r3, r1, r2
    checks++; if (fwda !== 2'b00) begin failures++; $display("FAIL b2b_empty_fwda got=%0d exp=0", fwda); end
    step();
    set_id(3, 4, 1, 1, 0, 9);  // add r9, r3, r4
    checks++; if (fwda !== 2'b01)        begin failures++; $display("FAIL b2b_e_fwda got=%0d exp=1", fwda); end
    checks++; if (fwdb !== 2'b00)        begin failures++; $display("FAIL b2b_e_fwdb got=%0d exp=0", fwdb); end
    checks++; if (pc_en !== 1'b1)        begin failures++; $display("FAIL b2b_no_stall got=%0d exp=1", pc_en); end
    step();
    set_id(3, 9, 1, 1, 0, 9);  // add r9, r3, r9
    checks++; if (fwda !== 2'b10)        begin failures++; $display("FAIL b2b_m_fwda got=%0d exp=2", fwda); end
    checks++; if (fwdb !== 2'b01)        begin failures++; $display("FAIL b2b_e_fwdb2 got=%0d exp=1", fwdb); end
    checks++; if (idexe_bubble !== 1'b0) begin failures++; $display("FAIL b2b_bubble got=%0d exp=0", idexe_bubble); end
    step();
    set_id(0, 9, 1, 0, 0, 0);  // r9 written by both E and M: E wins
    checks++; if (fwdb !== 2'b01) begin failures++; $display("FAIL b2b_priority_fwdb got=%0d exp=1", fwdb); end
    checks++; if (fwda !== 2'b00) begin failures++; $display("FAIL b2b_r0_fwda got=%0d exp=0", fwda); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 0, 0, 1, 1, 5);  // lw r5
    step();
    set_id(2, 5, 1, 1, 0, 6);  // add r6, r2, r5
    checks++; if (pc_en !== 1'b0)        begin failures++; $display("FAIL lu_pc_en got=%0d exp=0", pc_en); end
    checks++; if (ifid_en !== 1'b0)      begin failures++; $display("FAIL lu_ifid_en got=%0d exp=0", ifid_en); end
    checks++; if (idexe_bubble !== 1'b1) begin failures++; $display("FAIL lu_bubble got=%0d exp=1", idexe_bubble); end
    checks++; if (fwdb !== 2'b00)        begin failures++; $display("FAIL lu_stall_fwdb got=%0d exp=0", fwdb); end
    step();
    checks++; if (fwdb !== 2'b11)        begin failures++; $display("FAIL lu_mmem_fwdb got=%0d exp=3", fwdb); end
    checks++; if (pc_en !== 1'b1)        begin failures++; $display("FAIL lu_release_pc_en got=%0d exp=1", pc_en); end
    checks++; if (idexe_bubble !== 1'b0) begin failures++; $display("FAIL lu_release_bubble got=%0d exp=0", idexe_bubble); end
    checks++; if (stall_count !== 16'd1) begin failures++; $display("FAIL lu_stall_count got=%0d exp=1", stall_count); end
  endtask

  task automatic test_reg0_imm();
    do_reset();
    set_id(1, 2, 1, 1, 0, 0);  // add r0, r1, r2
    step();
    set_id(0, 0, 1, 0, 0, 0);
    checks++; if (fwda !== 2'b00)  begin failures++; $display("FAIL r0_fwda got=%0d exp=0", fwda); end
    checks++; if (fwdb !== 2'b00)  begin failures++; $display("FAIL r0_fwdb got=%0d exp=0", fwdb); end
    checks++; if (pc_en !== 1'b1)  begin failures++; $display("FAIL r0_no_stall got=%0d exp=1", pc_en); end
    set_id(1, 0, 0, 1, 1, 7);  // lw r7
    step();
    set_id(1, 7, 0, 1, 0, 8);  // immediate op: rt field is 7 but not read
    checks++; if (pc_en !== 1'b1)        begin failures++; $display("FAIL imm_no_stall got=%0d exp=1", pc_en); end
    checks++; if (idexe_bubble !== 1'b0) begin failures++; $display("FAIL imm_bubble got=%0d exp=0", idexe_bubble); end
    checks++; if (fwdb !== 2'b00)        begin failures++; $display("FAIL imm_fwdb got=%0d exp=0", fwdb); end
  endtask

  task automatic test_drain();
    do_reset();
    pc = 32'd124;
    #1;
    checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL drain_below_pc_en got=%0d exp=1", pc_en); end
    step();
    pc = 32'd128;
    #1;
    checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL drain_limit_cycle_pc_en got=%0d exp=1", pc_en); end
    step();
    pc = 32'd0;  // ignored from here on
    #1;
    checks++; if (pc_en !== 1'b0)      begin failures++; $display("FAIL drain_pc_en got=%0d exp=0", pc_en); end
    checks++; if (ifid_flush !== 1'b1) begin failures++; $display("FAIL drain_flush got=%0d exp=1", ifid_flush); end
    checks++; if (ifid_en !== 1'b1)    begin failures++; $display("FAIL drain_ifid_en got=%0d exp=1", ifid_en); end
    for (int i = 1; i < 4; i++) begin
      step();
      checks++; if (halted !== 1'b0)     begin failures++; $display("FAIL drain_early_halt_%0d got=%0d exp=0", i, halted); end
      checks++; if (ifid_flush !== 1'b1) begin failures++; $display("FAIL drain_flush_%0d got=%0d exp=1", i, ifid_flush); end
    end
    step();
    checks++; if (halted !== 1'b1)       begin failures++; $display("FAIL halt_halted got=%0d exp=1", halted); end
    checks++; if (pc_en !== 1'b0)        begin failures++; $display("FAIL halt_pc_en got=%0d exp=0", pc_en); end
    checks++; if (ifid_en !== 1'b0)      begin failures++; $display("FAIL halt_ifid_en got=%0d exp=0", ifid_en); end
    checks++; if (idexe_bubble !== 1'b1) begin failures++; $display("FAIL halt_bubble got=%0d exp=1", idexe_bubble); end
    checks++; if (ifid_flush !== 1'b0)   begin failures++; $display("FAIL halt_flush got=%0d exp=0", ifid_flush); end
    step(); step(); step();
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_stays got=%0d exp=1", halted); end
    checks++; if (pc_en !== 1'b0)  begin failures++; $display("FAIL halt_stays_pc_en got=%0d exp=0", pc_en); end
  endtask

  // Runs straight after test_drain, while the core is halted.
  task automatic test_reset_mid_halt();
    rst = 1'b1;
    set_id(5, 5, 1, 0, 0, 0);
    step();
    rst = 1'b0;
    #1;
    checks++; if (halted !== 1'b0)  begin failures++; $display("FAIL rsthalt_halted got=%0d exp=0", halted); end
    checks++; if (pc_en !== 1'b1)   begin failures++; $display("FAIL rsthalt_pc_en got=%0d exp=1", pc_en); end
    checks++; if (ifid_en !== 1'b1) begin failures++; $display("FAIL rsthalt_ifid_en got=%0d exp=1", ifid_en); end
    checks++; if (fwda !== 2'b00)   begin failures++; $display("FAIL rsthalt_fwda got=%0d exp=0", fwda); end
    checks++; if (fwdb !== 2'b00)   begin failures++; $display("FAIL rsthalt_fwdb got=%0d exp=0", fwdb); end
    step();
    checks++; if (halted !== 1'b0)  begin failures++; $display("FAIL rsthalt_run_halted got=%0d exp=0", halted); end
    checks++; if (pc_en !== 1'b1)   begin failures++; $display("FAIL rsthalt_run_pc_en got=%0d exp=1", pc_en); end
  endtask

  task automatic test_halt_precedence();
    do_reset();
    set_id(1, 0, 0, 1, 1, 5);  // lw r5
    step();
    pc = 32'd128;
    set_id(5, 0, 0, 0, 0, 0);  // load-use on the limit cycle
    checks++; if (pc_en !== 1'b0)      begin failures++; $display("FAIL prec_stall_pc_en got=%0d exp=0", pc_en); end
    checks++; if (ifid_flush !== 1'b0) begin failures++; $display("FAIL prec_stall_flush got=%0d exp=0", ifid_flush); end
    step();
    set_id(0, 0, 0, 0, 0, 0);
    checks++; if (pc_en !== 1'b1)      begin failures++; $display("FAIL prec_still_run got=%0d exp=1", pc_en); end
    checks++; if (ifid_flush !== 1'b0) begin failures++; $display("FAIL prec_still_run_flush got=%0d exp=0", ifid_flush); end
    step();
    checks++; if (pc_en !== 1'b0)      begin failures++; $display("FAIL prec_drain_pc_en got=%0d exp=0", pc_en); end
    checks++; if (ifid_flush !== 1'b1) begin failures++; $display("FAIL prec_drain_flush got=%0d exp=1", ifid_flush); end
  endtask

  task automatic test_drain_load_use();
    do_reset();
    pc = 32'd128;
    set_id(1, 0, 0, 1, 1, 5);  // lw r5 on the limit cycle, no hazard yet
    checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL dlu_entry_pc_en got=%0d exp=1", pc_en); end
    step();
    pc = 32'd0;
    set_id(5, 0, 0, 0, 0, 0);  // first DRAIN cycle hits load-use
    checks++; if (pc_en !== 1'b0)        begin failures++; $display("FAIL dlu_pc_en got=%0d exp=0", pc_en); end
    checks++; if (ifid_en !== 1'b0)      begin failures++; $display("FAIL dlu_ifid_en got=%0d exp=0", ifid_en); end
    checks++; if (ifid_flush !== 1'b0)   begin failures++; $display("FAIL dlu_flush got=%0d exp=0", ifid_flush); end
    checks++; if (idexe_bubble !== 1'b1) begin failures++; $display("FAIL dlu_bubble got=%0d exp=1", idexe_bubble); end
    step();
    set_id(0, 0, 0, 0, 0, 0);
    checks++; if (stall_count !== 16'd1) begin failures++; $display("FAIL dlu_stall_count got=%0d exp=1", stall_count); end
    checks++; if (ifid_flush !== 1'b1)   begin failures++; $display("FAIL dlu_resume_flush got=%0d exp=1", ifid_flush); end
    checks++; if (halted !== 1'b0)       begin failures++; $display("FAIL dlu_halt_1 got=%0d exp=0", halted); end
    for (int i = 2; i < 5; i++) begin
      step();
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL dlu_halt_%0d got=%0d exp=0", i, halted); end
    end
    step();
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL dlu_halt_5 got=%0d exp=1", halted); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_id(1, 0, 0, 1, 1, 5);  // lw r5
      step();
      set_id(5, 0, 0, 0, 0, 0);  // dependent read: one stall cycle
      step();
    end
    set_id(0, 0, 0, 0, 0, 0);
    checks++; if (stall_count2 !== 2'd3) begin failures++; $display("FAIL sat_cnt2 got=%0d exp=3", stall_count2); end
    checks++; if (stall_count !== 16'd5) begin failures++; $display("FAIL sat_cnt16 got=%0d exp=5", stall_count); end
  endtask

  initial begin
    rst = 1'b1;
    pc  = 32'd0;
    id_rs = '0; id_rt = '0; id_dest = '0;
    id_uses_rt = 1'b0; id_wreg = 1'b0; id_m2reg = 1'b0;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_reg0_imm();
    test_drain();
    test_reset_mid_halt();
    test_halt_precedence();
    test_drain_load_use();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
